// File: rtl/bank_sequencer_if.sv
// bank_sequencer_if -- sample/memory-bank/output bus of the bank sequencer.
//   slave  : sequencer side (accepts in_*, drives memory bank and out_*)
//   master : environment side (offers samples, models the bank, consumes out_*)
// Signals:
//   in_valid/in_data/in_ready       : sample input handshake, {re[31:16], im[15:0]}
//   write_add/write_data/memwrite_en: memory bank write port
//   read_add/read_data              : memory bank combinational read port
//   out_valid/out_data/out_last/out_ready : drained sample output handshake
interface bank_sequencer_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [2:0]  write_add;
  logic [31:0] write_data;
  logic        memwrite_en;
  logic [2:0]  read_add;
  logic [31:0] read_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;

  modport slave (
    input  in_valid, in_data, read_data, out_ready,
    output in_ready, write_add, write_data, memwrite_en, read_add,
           out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, read_data, out_ready,
    input  in_ready, write_add, write_data, memwrite_en, read_add,
           out_valid, out_data, out_last
  );
endinterface

// File: rtl/bank_sequencer.sv
// bank_sequencer -- fills an external 8-word memory bank in natural order, then
// drains it through a registered output stage, one frame at a time.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : bank_sequencer_if.slave (sample in, bank write/read, sample out)
// Build option:
//   BANK_BITREV_EN : drain in 3-bit bit-reversed order (0,4,2,6,1,5,3,7)
//                    instead of natural order 0..7.
module bank_sequencer (
  input  logic                clk,
  input  logic                rst_n,
  bank_sequencer_if.slave     bus
);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t      state;
  logic [2:0]  wr_cnt;
  logic [3:0]  rd_cnt;
  logic        out_valid_q;
  logic [31:0] out_data_q;
  logic        out_last_q;

  logic        accept;
  logic        load;

  function automatic logic [2:0] order(input logic [2:0] k);
`ifdef BANK_BITREV_EN
    return {k[0], k[1], k[2]};
`else
    return k;
`endif
  endfunction

  assign bus.in_ready    = (state == FILL);
  assign accept          = bus.in_valid & bus.in_ready;
  assign bus.memwrite_en = accept;
  assign bus.write_add   = wr_cnt;
  assign bus.write_data  = bus.in_data;
  assign bus.read_add    = order(rd_cnt[2:0]);

  // The output register is refilled whenever it is empty or being consumed,
  // so a drain with out_ready held high streams one word per cycle.
  assign load = (state == DRAIN) && (rd_cnt < 4'd8) && (!out_valid_q || bus.out_ready);

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FILL;
      wr_cnt      <= 3'd0;
      rd_cnt      <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            wr_cnt <= wr_cnt + 3'd1;     // wraps to 0 after the 8th write
            if (wr_cnt == 3'd7) begin
              state  <= DRAIN;
              rd_cnt <= 4'd0;
            end
          end
        end
        DRAIN: begin
          if (load) begin
            rd_cnt <= rd_cnt + 4'd1;
            // Leave on the final load: the last word sits in the output
            // register while the next frame starts filling.
            if (rd_cnt == 4'd7) state <= FILL;
          end
        end
        default: state <= FILL;
      endcase

      if (load) begin
        out_data_q  <= bus.read_data;
        out_valid_q <= 1'b1;
        out_last_q  <= (rd_cnt == 4'd7);
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bank_sequencer.sv
module tb_bank_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bank_sequencer_if bus();
  bank_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Memory bank model: synchronous write, combinational read.
  logic [31:0] mem [8];
  always @(posedge clk) if (bus.memwrite_en) mem[bus.write_add] <= bus.write_data;
  assign bus.read_data = mem[bus.read_add];

  typedef struct { logic [31:0] d; logic l; } exp_t;

  // Reference model: words collected per frame, a frame becomes 8 pending
  // output words in drain order, and one output slot.
  logic [31:0] fill_q[$];
  exp_t        exp_q[$];
  int          pend = 0;
  bit          slot_v = 0;
  bit          m_acc = 0;
  bit          m_ld;
  bit          chk_en = 0;
  int          total = 0, bad = 0;
  int          n_xfer = 0, n_last = 0;

  function automatic int ord(int k);
`ifdef BANK_BITREV_EN
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
    return k;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_acc = 0;
    if (!rst_n) begin
      fill_q.delete(); exp_q.delete(); pend = 0; slot_v = 0;
    end else begin
      m_ld = (pend > 0) && (!slot_v || bus.out_ready);
      if (bus.in_valid && pend == 0) begin
        m_acc = 1;
        fill_q.push_back(bus.in_data);
        if (fill_q.size() == 8) begin
          for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.d = fill_q[ord(k)];
            e.l = (k == 7);
            exp_q.push_back(e);
          end
          fill_q.delete();
          pend = 8;
        end
      end
      if (m_ld) begin pend--; slot_v = 1; end
      else if (slot_v && bus.out_ready) slot_v = 0;
    end
  end

  // Monitor: sampled on the falling edge, after inputs and state settled.
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, pend == 0});
      chk("memwrite_en", {31'd0, bus.memwrite_en}, {31'd0, bus.in_valid && pend == 0});
      if (bus.memwrite_en) chk("write_add", {29'd0, bus.write_add}, fill_q.size());
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, slot_v});
      if (prev_stall) begin
        chk("hold_data", bus.out_data, prev_data);
        chk("hold_last", {31'd0, bus.out_last}, {31'd0, prev_last});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL out_extra act=%h exp=none", bus.out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("out_last", {31'd0, bus.out_last}, {31'd0, e.l});
        end
        n_xfer++;
        if (bus.out_last) n_last++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end else begin
      prev_stall = 0;
    end
  end

  // mode 0: always ready; 1: random valid/ready; 2: 5-cycle stall on first
  // out_valid; 3: stall the frame-final word for 4 cycles.
  task automatic feed(int n, logic [31:0] base, int mode, bit drain);
    int sent = 0, budget = 0, stall = 0, lstall = 0;
    bit stalled = 0;
    int lim = n * 24 + 200;
    while ((sent < n || (drain && (pend > 0 || slot_v))) && budget < lim) begin
      if (sent < n && pend == 0) begin
        bus.in_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.in_data  = base + 32'((sent / 8) * 16 + (sent % 8));
      end else begin
        bus.in_valid = (pend > 0);
        bus.in_data  = 32'hDEADBEEF;
      end
      case (mode)
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (slot_v && !stalled) begin stall = 5; stalled = 1; end
          bus.out_ready = (stall == 0);
          if (stall > 0) stall--;
        end
        3: begin
          if (bus.out_valid && bus.out_last && lstall < 4) begin
            bus.out_ready = 1'b0; lstall++;
          end else begin
            bus.out_ready = 1'b1;
            if (!(bus.out_valid && bus.out_last)) lstall = 0;
          end
        end
        default: bus.out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      if (m_acc) sent++;
      budget++;
    end
    bus.in_valid = 1'b0;
    if (budget >= lim) begin
      total++; bad++;
      $display("FAIL feed_timeout act=%0d words exp=%0d", sent, n);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    chk_en = 1;

    feed(8, 32'h0, 0, 1);            // natural / bit-reversed order
    feed(8, 32'h100, 2, 1);          // output stall, hold stable
    feed(8, 32'h200, 0, 1);          // DEADBEEF offered during drain
    feed(16, 32'h10, 3, 1);          // back-to-back frames, last word stalled

    feed(4, 32'hF0, 0, 0);           // partial frame then reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    rst_n = 1'b1;
    feed(8, 32'hA0, 0, 1);

    feed(800, 32'h1000, 1, 1);       // 100 random frames

    chk("end_pending", pend, 0);
    chk("end_exp_q", exp_q.size(), 0);
    chk("last_count", n_last * 8, n_xfer);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
